// File: rtl/eq_pkg.sv
// Shared equalizer types: sample width, stereo pair packing and the
// sample-queue FSM state encoding.
package eq_pkg;

  localparam int SMPL_W = 16;

  typedef logic signed [SMPL_W-1:0] smpl_t;

  typedef struct packed {
    smpl_t lft;
    smpl_t rght;
  } stereo_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } sq_state_t;

endpackage

// File: rtl/smpl_queue_if.sv
// Sample-queue bus: sample-in strobe/data and stream-out data/valid.
// Optional macro SMPL_QUEUE_OVERRUN_EN adds the sticky overrun flag.
interface smpl_queue_if;
  import eq_pkg::*;

  logic  wrt_smpl;
  smpl_t lft_smpl;
  smpl_t rght_smpl;
  smpl_t lft_out;
  smpl_t rght_out;
  logic  sequencing;
`ifdef SMPL_QUEUE_OVERRUN_EN
  logic  overrun;
`endif

  // Sample producer / stream consumer side
  modport master (
    output wrt_smpl, lft_smpl, rght_smpl,
`ifdef SMPL_QUEUE_OVERRUN_EN
    input  overrun,
`endif
    input  lft_out, rght_out, sequencing
  );

  // Queue side
  modport slave (
    input  wrt_smpl, lft_smpl, rght_smpl,
`ifdef SMPL_QUEUE_OVERRUN_EN
    output overrun,
`endif
    output lft_out, rght_out, sequencing
  );

endinterface

// File: rtl/dp_ram_sq.sv
// Simple dual-port RAM for the sample queue: one write port, one
// registered read port (1-cycle latency), no reset on contents.
module dp_ram_sq #(
  parameter int DEPTH = 1021,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/smpl_queue.sv
// Circular stereo sample queue feeding an FIR band stage. Keeps the last
// DEPTH samples; once full, every new sample triggers a stream of all DEPTH
// samples oldest-to-newest, one per clock, qualified by sequencing.
// Optional macro SMPL_QUEUE_OVERRUN_EN adds a sticky overrun flag set when
// a sample arrives while a stream is still in flight.
module smpl_queue
  import eq_pkg::*;
#(
  parameter int DEPTH = 1021
) (
  input  logic         clk,
  input  logic         rst_n,
  smpl_queue_if.slave  sq
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_TOP = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] new_ptr_q, new_ptr_d;
  logic [AW-1:0] old_ptr_q, old_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic          full_q, full_d;
  sq_state_t     state_q, state_d;

  logic          rd_en;
  logic          rd_vld_q, rd_vld_dly_q;
  stereo_t       rd_data, dat_dly_q;
  smpl_t         lft_out_q, rght_out_q;
  logic          seq_q;

  logic          busy, accept, trig;
  stereo_t       wr_data;

  // Samples are dropped until the whole stream has left the RAM pipeline;
  // the output register stage itself does not block a new write.
  assign busy    = (state_q == READ) | rd_vld_q | rd_vld_dly_q;
  assign accept  = sq.wrt_smpl & ~busy;
  assign trig    = accept & (full_q | (cnt_q == CNT_TOP));
  assign wr_data = '{lft: sq.lft_smpl, rght: sq.rght_smpl};

  // Write-side pointers, fill count and full flag
  always_comb begin
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    if (accept) begin
      new_ptr_d = (new_ptr_q == LAST) ? '0 : new_ptr_q + 1'b1;
      if (full_q) begin
        // overwrote the oldest entry, so the oldest moves up by one
        old_ptr_d = (old_ptr_q == LAST) ? '0 : old_ptr_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_TOP) full_d = 1'b1;
      end
    end
  end

  // FSM next-state: issue DEPTH read addresses starting at the oldest entry
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_cnt_d = rd_cnt_q;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d  = READ;
          rd_ptr_d = old_ptr_d;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == CNT_TOP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  dp_ram_sq #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (2 * SMPL_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (new_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Output pipeline: valid tracks RAM latency, then one staging register
  // ahead of the output registers; outputs hold the last beat when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q     <= 1'b0;
      rd_vld_dly_q <= 1'b0;
      dat_dly_q    <= '0;
      lft_out_q    <= '0;
      rght_out_q   <= '0;
      seq_q        <= 1'b0;
    end else begin
      rd_vld_q     <= rd_en;
      rd_vld_dly_q <= rd_vld_q;
      if (rd_vld_q) dat_dly_q <= rd_data;
      if (rd_vld_dly_q) begin
        lft_out_q  <= dat_dly_q.lft;
        rght_out_q <= dat_dly_q.rght;
      end
      seq_q        <= rd_vld_dly_q;
    end
  end

  assign sq.lft_out    = lft_out_q;
  assign sq.rght_out   = rght_out_q;
  assign sq.sequencing = seq_q;

`ifdef SMPL_QUEUE_OVERRUN_EN
  logic drop;
  logic ovr_q;

  assign drop = sq.wrt_smpl & busy;

  // Sticky overrun: any sample dropped since reset
  always_ff @(posedge clk) begin
    if (!rst_n)    ovr_q <= 1'b0;
    else if (drop) ovr_q <= 1'b1;
  end

  assign sq.overrun = ovr_q;
`endif

endmodule
